id_ex_stage: RTL and testbench

- Decode-to-execute stage that consumes the two register-file read words (qa, qb) for the instruction in decode.
- Resolves operand hazards by forwarding from the EX and MEM stages.
- Detects load-use interlocks and drives the upstream stall.
- Captures operands and control into the ID/EX pipeline register that feeds the ALU stage.

---
 rtl/id_ex_stage.sv | 148 ++++++++++++++
 tb/tb_id_ex_stage.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline stage: operand forwarding, load-use interlock, stall counter.
// Optional WB-stage bypass source is enabled with `define ID_EX_WB_BYPASS_EN.
module id_ex_stage #(
    parameter int CTRL_W      = 8,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   clrn,
    input  logic [4:0]             d_rs,
    input  logic [4:0]             d_rt,
    input  logic                   d_use_rs,
    input  logic                   d_use_rt,
    input  logic [4:0]             d_wn,
    input  logic                   d_wreg,
    input  logic                   d_m2reg,
    input  logic [CTRL_W-1:0]      d_ctrl,
    input  logic [31:0]            d_imm,
    input  logic [31:0]            qa,
    input  logic [31:0]            qb,
    input  logic [4:0]             ex_wn,
    input  logic                   ex_wreg,
    input  logic                   ex_m2reg,
    input  logic [31:0]            ex_alu,
    input  logic [4:0]             mem_wn,
    input  logic                   mem_wreg,
    input  logic                   mem_m2reg,
    input  logic [31:0]            mem_alu,
    input  logic [31:0]            mem_mdata,
`ifdef ID_EX_WB_BYPASS_EN
    input  logic [4:0]             wb_wn,
    input  logic                   wb_wreg,
    input  logic [31:0]            wb_data,
`endif
    input  logic                   flush,
    input  logic                   ex_hold,
    output logic                   stall,
    output logic                   e_valid,
    output logic [31:0]            e_a,
    output logic [31:0]            e_b,
    output logic [31:0]            e_imm,
    output logic [4:0]             e_wn,
    output logic                   e_wreg,
    output logic                   e_m2reg,
    output logic [CTRL_W-1:0]      e_ctrl,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    logic [31:0]            w_fwd_a;
    logic [31:0]            w_fwd_b;
    logic                   w_lu;
    logic                   w_stall;

    logic                   r_valid;
    logic [31:0]            r_a;
    logic [31:0]            r_b;
    logic [31:0]            r_imm;
    logic [4:0]             r_wn;
    logic                   r_wreg;
    logic                   r_m2reg;
    logic [CTRL_W-1:0]      r_ctrl;
    logic [STALL_CNT_W-1:0] r_stall_cnt;

    // EX beats MEM; a load still in EX cannot forward and is caught by the interlock.
    always_comb begin
        w_fwd_a = qa;
        if (d_rs == 5'd0)
            w_fwd_a = '0;
        else if (ex_wreg && (ex_wn == d_rs) && !ex_m2reg)
            w_fwd_a = ex_alu;
        else if (mem_wreg && (mem_wn == d_rs))
            w_fwd_a = mem_m2reg ? mem_mdata : mem_alu;
`ifdef ID_EX_WB_BYPASS_EN
        else if (wb_wreg && (wb_wn == d_rs))
            w_fwd_a = wb_data;
`endif
    end

    always_comb begin
        w_fwd_b = qb;
        if (d_rt == 5'd0)
            w_fwd_b = '0;
        else if (ex_wreg && (ex_wn == d_rt) && !ex_m2reg)
            w_fwd_b = ex_alu;
        else if (mem_wreg && (mem_wn == d_rt))
            w_fwd_b = mem_m2reg ? mem_mdata : mem_alu;
`ifdef ID_EX_WB_BYPASS_EN
        else if (wb_wreg && (wb_wn == d_rt))
            w_fwd_b = wb_data;
`endif
    end

    assign w_lu = ex_wreg && ex_m2reg && (ex_wn != 5'd0) &&
                  ((d_use_rs && (ex_wn == d_rs)) || (d_use_rt && (ex_wn == d_rt)));

    assign w_stall = ex_hold | (w_lu & ~flush);

    always_ff @(posedge clk) begin
        if (clrn) begin
            r_valid <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_imm   <= '0;
            r_wn    <= '0;
            r_wreg  <= 1'b0;
            r_m2reg <= 1'b0;
            r_ctrl  <= '0;
        end else if (ex_hold) begin
            r_valid <= r_valid;
        end else if (flush || w_lu) begin
            r_valid <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_imm   <= '0;
            r_wn    <= '0;
            r_wreg  <= 1'b0;
            r_m2reg <= 1'b0;
            r_ctrl  <= '0;
        end else begin
            r_valid <= 1'b1;
            r_a     <= w_fwd_a;
            r_b     <= w_fwd_b;
            r_imm   <= d_imm;
            r_wn    <= d_wn;
            r_wreg  <= d_wreg;
            r_m2reg <= d_m2reg;
            r_ctrl  <= d_ctrl;
        end
    end

    always_ff @(posedge clk) begin
        if (clrn)
            r_stall_cnt <= '0;
        else if (w_stall && (r_stall_cnt != '1))
            r_stall_cnt <= r_stall_cnt + STALL_CNT_W'(1);
    end

    assign stall     = w_stall;
    assign e_valid   = r_valid;
    assign e_a       = r_a;
    assign e_b       = r_b;
    assign e_imm     = r_imm;
    assign e_wn      = r_wn;
    assign e_wreg    = r_wreg;
    assign e_m2reg   = r_m2reg;
    assign e_ctrl    = r_ctrl;
    assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage (default build, 2-bit stall counter).
module tb_id_ex_stage;

    localparam int CTRL_W      = 8;
    localparam int STALL_CNT_W = 2;

    logic                   clk = 1'b0;
    logic                   clrn;
    logic [4:0]             d_rs, d_rt, d_wn;
    logic                   d_use_rs, d_use_rt, d_wreg, d_m2reg;
    logic [CTRL_W-1:0]      d_ctrl;
    logic [31:0]            d_imm, qa, qb;
    logic [4:0]             ex_wn, mem_wn;
    logic                   ex_wreg, ex_m2reg, mem_wreg, mem_m2reg;
    logic [31:0]            ex_alu, mem_alu, mem_mdata;
    logic                   flush, ex_hold;
    logic                   stall, e_valid, e_wreg, e_m2reg;
    logic [31:0]            e_a, e_b, e_imm;
    logic [4:0]             e_wn;
    logic [CTRL_W-1:0]      e_ctrl;
    logic [STALL_CNT_W-1:0] stall_cnt;

    int tests = 0;
    int fails = 0;

    id_ex_stage #(.CTRL_W(CTRL_W), .STALL_CNT_W(STALL_CNT_W)) dut (
        .clk(clk), .clrn(clrn),
        .d_rs(d_rs), .d_rt(d_rt), .d_use_rs(d_use_rs), .d_use_rt(d_use_rt),
        .d_wn(d_wn), .d_wreg(d_wreg), .d_m2reg(d_m2reg), .d_ctrl(d_ctrl),
        .d_imm(d_imm), .qa(qa), .qb(qb),
        .ex_wn(ex_wn), .ex_wreg(ex_wreg), .ex_m2reg(ex_m2reg), .ex_alu(ex_alu),
        .mem_wn(mem_wn), .mem_wreg(mem_wreg), .mem_m2reg(mem_m2reg),
        .mem_alu(mem_alu), .mem_mdata(mem_mdata),
        .flush(flush), .ex_hold(ex_hold),
        .stall(stall), .e_valid(e_valid), .e_a(e_a), .e_b(e_b), .e_imm(e_imm),
        .e_wn(e_wn), .e_wreg(e_wreg), .e_m2reg(e_m2reg), .e_ctrl(e_ctrl),
        .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic defaults();
        d_rs = 0; d_rt = 0; d_use_rs = 0; d_use_rt = 0; d_wn = 0;
        d_wreg = 0; d_m2reg = 0; d_ctrl = 0; d_imm = 0; qa = 0; qb = 0;
        ex_wn = 0; ex_wreg = 0; ex_m2reg = 0; ex_alu = 0;
        mem_wn = 0; mem_wreg = 0; mem_m2reg = 0; mem_alu = 0; mem_mdata = 0;
        flush = 0; ex_hold = 0;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        defaults();
        // Reset with a live-looking instruction on the inputs
        clrn = 1; d_rs = 1; qa = 32'd5; d_wreg = 1; d_wn = 3; d_ctrl = 8'hFF;
        #2;
        step();
        check("rst_valid", 32'(e_valid), 32'd0);
        check("rst_a", e_a, 32'd0);
        check("rst_wreg", 32'(e_wreg), 32'd0);
        check("rst_ctrl", 32'(e_ctrl), 32'd0);
        check("rst_cnt", 32'(stall_cnt), 32'd0);
        check("rst_stall", 32'(stall), 32'd0);
        clrn = 0;

        // Plain pass-through, no hazards
        defaults();
        d_rs = 1; qa = 32'd5; d_rt = 2; qb = 32'd9; d_wn = 7; d_wreg = 1;
        d_m2reg = 1; d_ctrl = 8'h3C; d_imm = 32'hFFFF_FFF0;
        step();
        check("pass_valid", 32'(e_valid), 32'd1);
        check("pass_a", e_a, 32'd5);
        check("pass_b", e_b, 32'd9);
        check("pass_wn", 32'(e_wn), 32'd7);
        check("pass_wreg", 32'(e_wreg), 32'd1);
        check("pass_m2reg", 32'(e_m2reg), 32'd1);
        check("pass_ctrl", 32'(e_ctrl), 32'h3C);
        check("pass_imm", e_imm, 32'hFFFF_FFF0);

        // EX forward has priority over MEM
        defaults();
        d_rs = 3; qa = 32'd1; d_rt = 2; qb = 32'd9; d_use_rs = 1;
        ex_wn = 3; ex_wreg = 1; ex_alu = 32'hAA;
        mem_wn = 3; mem_wreg = 1; mem_alu = 32'hBB;
        #1;
        check("exfwd_stall", 32'(stall), 32'd0);
        step();
        check("exfwd_a", e_a, 32'hAA);
        check("exfwd_b", e_b, 32'd9);

        // Same with EX not writing: MEM ALU result wins
        ex_wreg = 0;
        step();
        check("memalu_a", e_a, 32'hBB);

        // MEM load data on B; $0 never forwarded on A
        defaults();
        d_rt = 4; qb = 32'd2; mem_wn = 4; mem_wreg = 1; mem_m2reg = 1;
        mem_mdata = 32'h1234; mem_alu = 32'hDEAD;
        d_rs = 0; qa = 32'h99; ex_wn = 0; ex_wreg = 1; ex_alu = 32'd7;
        step();
        check("memld_b", e_b, 32'h1234);
        check("zero_a", e_a, 32'd0);

        // Load-use interlock on rs
        defaults();
        ex_wreg = 1; ex_m2reg = 1; ex_wn = 5; d_rs = 5; d_use_rs = 1; qa = 32'h11;
        d_wreg = 1;
        #1;
        check("lu_stall", 32'(stall), 32'd1);
        step();
        check("lu_valid", 32'(e_valid), 32'd0);
        check("lu_wreg", 32'(e_wreg), 32'd0);
        check("lu_cnt", 32'(stall_cnt), 32'd1);
        // The load has moved to MEM; its data is forwarded
        ex_wreg = 0; ex_m2reg = 0; ex_wn = 0;
        mem_wn = 5; mem_wreg = 1; mem_m2reg = 1; mem_mdata = 32'h55;
        #1;
        check("lu2_stall", 32'(stall), 32'd0);
        step();
        check("lu2_a", e_a, 32'h55);
        check("lu2_valid", 32'(e_valid), 32'd1);
        check("lu2_cnt", 32'(stall_cnt), 32'd1);

        // No interlock when rt is unused or the load targets $0
        defaults();
        ex_wreg = 1; ex_m2reg = 1; ex_wn = 6; d_rt = 6; d_use_rt = 0;
        #1;
        check("lu_unused_rt", 32'(stall), 32'd0);
        ex_wn = 0; d_rt = 0; d_use_rt = 1;
        #1;
        check("lu_r0", 32'(stall), 32'd0);
        ex_wn = 6; d_rt = 6;
        #1;
        check("lu_rt", 32'(stall), 32'd1);

        // Flush beats load-use
        defaults();
        ex_wreg = 1; ex_m2reg = 1; ex_wn = 5; d_rs = 5; d_use_rs = 1;
        d_wreg = 1; d_ctrl = 8'h81; flush = 1;
        #1;
        check("flush_stall", 32'(stall), 32'd0);
        step();
        check("flush_valid", 32'(e_valid), 32'd0);
        check("flush_wreg", 32'(e_wreg), 32'd0);
        check("flush_ctrl", 32'(e_ctrl), 32'd0);
        check("flush_cnt", 32'(stall_cnt), 32'd1);

        // Hold freezes ID/EX; counter saturates at 3
        defaults();
        d_rs = 1; qa = 32'h77; d_wreg = 1; d_wn = 9; d_ctrl = 8'h5A;
        step();
        check("prehold_a", e_a, 32'h77);
        ex_hold = 1; qa = 32'h88; d_wn = 2; d_ctrl = 8'h00; d_wreg = 0;
        for (int i = 1; i <= 5; i++) begin
            #1;
            check("hold_stall", 32'(stall), 32'd1);
            step();
            check("hold_a", e_a, 32'h77);
            check("hold_wn", 32'(e_wn), 32'd9);
            check("hold_ctrl", 32'(e_ctrl), 32'h5A);
            check("hold_valid", 32'(e_valid), 32'd1);
            check("hold_cnt", 32'(stall_cnt), (1 + i > 3) ? 32'd3 : 32'(1 + i));
        end
        ex_hold = 0;
        #1;
        check("unhold_stall", 32'(stall), 32'd0);
        step();
        check("unhold_a", e_a, 32'h88);
        check("unhold_wn", 32'(e_wn), 32'd2);
        check("sat_cnt", 32'(stall_cnt), 32'd3);

        // Reset in the middle of an interlock
        defaults();
        ex_wreg = 1; ex_m2reg = 1; ex_wn = 5; d_rs = 5; d_use_rs = 1;
        clrn = 1;
        step();
        check("rststall_valid", 32'(e_valid), 32'd0);
        check("rststall_cnt", 32'(stall_cnt), 32'd0);
        check("rststall_stall", 32'(stall), 32'd1);
        clrn = 0;
        ex_wreg = 0;
        #1;
        check("rststall_clear", 32'(stall), 32'd0);
        step();
        check("rststall_cnt2", 32'(stall_cnt), 32'd0);
        check("rststall_valid2", 32'(e_valid), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
